// File: rtl/gpmc_slave_bridge.sv
// gpmc_slave_bridge
// Device-side endpoint of an asynchronous, non-multiplexed GPMC bus. Single
// host accesses are turned into one-cycle register read/write strobes in the
// fabric clock domain. The host is stalled through gpmc_wait until read data
// returns or the read times out.
//
// Ports
//   clk, rst           fabric clock, asynchronous active-high reset
//   gpmc_cs_n/adv_n/oe_n/we_n   host strobes (active low, asynchronous)
//   gpmc_be_n          host byte enables (active low)
//   gpmc_addr          host address bus
//   gpmc_data_o        write data driven by the host
//   gpmc_data_i        read data returned to the host
//   gpmc_wait          stall to host (1 = wait)
//   wr_en/wr_addr/wr_data/wr_be   fabric write strobe and payload
//   rd_en/rd_addr      fabric read request
//   rd_data/rd_valid   fabric read response
//   rd_timeout         one-cycle pulse when a read is aborted by timeout
module gpmc_slave_bridge #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RD_TIMEOUT  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gpmc_cs_n,
    input  logic                  gpmc_adv_n,
    input  logic                  gpmc_oe_n,
    input  logic                  gpmc_we_n,
    input  logic [1:0]            gpmc_be_n,
    input  logic [ADDR_WIDTH-1:0] gpmc_addr,
    input  logic [DATA_WIDTH-1:0] gpmc_data_o,
    output logic [DATA_WIDTH-1:0] gpmc_data_i,
    output logic                  gpmc_wait,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [1:0]            wr_be,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_valid,
    output logic                  rd_timeout
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WRITE, S_READ_WAIT, S_READ_HOLD, S_DONE
    } state_t;

    state_t state_q, state_d;

    // Strobe synchronisers; reset to 1 so the bus looks idle.
    logic [SYNC_STAGES-1:0] cs_sync_q, adv_sync_q, oe_sync_q, we_sync_q;
    logic                   cs_prev_q, adv_prev_q, oe_prev_q, we_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q  <= '1;
            adv_sync_q <= '1;
            oe_sync_q  <= '1;
            we_sync_q  <= '1;
            cs_prev_q  <= 1'b1;
            adv_prev_q <= 1'b1;
            oe_prev_q  <= 1'b1;
            we_prev_q  <= 1'b1;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], gpmc_cs_n};
            adv_sync_q <= {adv_sync_q[SYNC_STAGES-2:0], gpmc_adv_n};
            oe_sync_q  <= {oe_sync_q[SYNC_STAGES-2:0], gpmc_oe_n};
            we_sync_q  <= {we_sync_q[SYNC_STAGES-2:0], gpmc_we_n};
            cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
            adv_prev_q <= adv_sync_q[SYNC_STAGES-1];
            oe_prev_q  <= oe_sync_q[SYNC_STAGES-1];
            we_prev_q  <= we_sync_q[SYNC_STAGES-1];
        end
    end

    logic cs_s, oe_s, we_s;
    logic cs_rise, adv_rise, oe_fall, oe_rise, we_fall, we_rise;

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign oe_s     = oe_sync_q[SYNC_STAGES-1];
    assign we_s     = we_sync_q[SYNC_STAGES-1];
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign adv_rise = adv_sync_q[SYNC_STAGES-1] & ~adv_prev_q;
    assign oe_fall  = ~oe_s & oe_prev_q;
    assign oe_rise  = oe_s & ~oe_prev_q;
    assign we_fall  = ~we_s & we_prev_q;
    assign we_rise  = we_s & ~we_prev_q;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d, data_i_q, data_i_d;
    logic [1:0]            wr_be_q, wr_be_d;
    logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic                  wait_q, wait_d, tmo_q, tmo_d;
    logic                  wr_pend_q, wr_pend_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
            data_i_q  <= '0;
            wr_be_q   <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wait_q    <= 1'b0;
            tmo_q     <= 1'b0;
            wr_pend_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_data_q <= wr_data_d;
            data_i_q  <= data_i_d;
            wr_be_q   <= wr_be_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            wait_q    <= wait_d;
            tmo_q     <= tmo_d;
            wr_pend_q <= wr_pend_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        wr_data_d = wr_data_q;
        data_i_d  = data_i_q;
        wr_be_d   = wr_be_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        wait_d    = wait_q;
        tmo_d     = 1'b0;
        wr_pend_d = wr_pend_q;
        cnt_d     = cnt_q;

        if (state_q != S_IDLE && cs_rise) begin
            // Host released chip select: abandon the access. A write whose
            // data was already captured is still delivered.
            wr_en_d   = (state_q == S_WRITE) && wr_pend_q;
            wr_pend_d = 1'b0;
            wait_d    = 1'b0;
            state_d   = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wr_pend_d = 1'b0;
                    if (!cs_s) state_d = S_ADDR;
                end
                S_ADDR: begin
                    if (adv_rise) addr_d = gpmc_addr;
                    if (oe_fall || we_fall) begin
                        if (!oe_s && !we_s) begin
                            state_d = S_DONE;          // both strobes low: protocol error
                        end else if (we_fall) begin
                            state_d = S_WRITE;
                        end else begin
                            rd_en_d   = 1'b1;
                            rd_addr_d = adv_rise ? gpmc_addr : addr_q;
                            wait_d    = 1'b1;
                            cnt_d     = '0;
                            state_d   = S_READ_WAIT;
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_pend_q) begin
                        wr_en_d   = 1'b1;
                        wr_pend_d = 1'b0;
                        state_d   = S_DONE;
                    end else if (we_rise) begin
                        wr_addr_d = addr_q;
                        wr_data_d = gpmc_data_o;
                        wr_be_d   = ~gpmc_be_n;
                        wr_pend_d = 1'b1;
                    end
                end
                S_READ_WAIT: begin
                    // rd_valid has priority over an expiring timeout.
                    if (rd_valid) begin
                        data_i_d = rd_data;
                        wait_d   = 1'b0;
                        state_d  = S_READ_HOLD;
                    end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                        data_i_d = '1;
                        tmo_d    = 1'b1;
                        wait_d   = 1'b0;
                        state_d  = S_READ_HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_READ_HOLD: begin
                    if (oe_rise) state_d = S_DONE;
                end
                S_DONE: begin
                    if (cs_s) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign gpmc_data_i = data_i_q;
    assign gpmc_wait   = wait_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign wr_be       = wr_be_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign rd_timeout  = tmo_q;

endmodule

// File: tb/tb_gpmc_slave_bridge.sv
module tb_gpmc_slave_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        gpmc_cs_n, gpmc_adv_n, gpmc_oe_n, gpmc_we_n;
    logic [1:0]  gpmc_be_n;
    logic [15:0] gpmc_addr, gpmc_data_o, gpmc_data_i;
    logic        gpmc_wait;
    logic        wr_en, rd_en, rd_valid, rd_timeout;
    logic [15:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [1:0]  wr_be;

    gpmc_slave_bridge #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .SYNC_STAGES(2), .RD_TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst),
        .gpmc_cs_n(gpmc_cs_n), .gpmc_adv_n(gpmc_adv_n),
        .gpmc_oe_n(gpmc_oe_n), .gpmc_we_n(gpmc_we_n),
        .gpmc_be_n(gpmc_be_n), .gpmc_addr(gpmc_addr),
        .gpmc_data_o(gpmc_data_o), .gpmc_data_i(gpmc_data_i),
        .gpmc_wait(gpmc_wait),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_timeout(rd_timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0, rd_cnt = 0, to_cnt = 0;
    int w0, r0, t0;

    always @(negedge clk) begin
        if (wr_en)      wr_cnt++;
        if (rd_en)      rd_cnt++;
        if (rd_timeout) to_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        w0 = wr_cnt; r0 = rd_cnt; t0 = to_cnt;
    endtask

    task automatic start(input logic [15:0] a);
        gpmc_addr  = a;
        gpmc_cs_n  = 1'b0;
        gpmc_adv_n = 1'b0;
        tick(4);
        gpmc_adv_n = 1'b1;
        tick(4);
    endtask

    task automatic finish_cs();
        gpmc_oe_n = 1'b1;
        gpmc_we_n = 1'b1;
        tick(4);
        gpmc_cs_n = 1'b1;
        tick(6);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] ben);
        start(a);
        gpmc_data_o = d;
        gpmc_be_n   = ben;
        gpmc_we_n   = 1'b0;
        tick(4);
        gpmc_we_n   = 1'b1;
        tick(6);
        finish_cs();
    endtask

    initial begin
        rst = 1'b1;
        gpmc_cs_n = 1'b1; gpmc_adv_n = 1'b1; gpmc_oe_n = 1'b1; gpmc_we_n = 1'b1;
        gpmc_be_n = 2'b11; gpmc_addr = '0; gpmc_data_o = '0;
        rd_data = '0; rd_valid = 1'b0;
        tick(3);
        chk("reset_wait", gpmc_wait, 0);
        chk("reset_data_i", gpmc_data_i, 0);
        chk("reset_strobes", {wr_en, rd_en, rd_timeout}, 0);
        chk("reset_wr_bus", {wr_addr, wr_data, wr_be}, 0);
        rst = 1'b0;
        tick(4);

        // Full write with latency check
        snap();
        start(16'h0042);
        gpmc_data_o = 16'hBEEF;
        gpmc_be_n   = 2'b00;
        gpmc_we_n   = 1'b0;
        tick(4);
        gpmc_we_n   = 1'b1;
        tick(3);
        chk("wr_en_early", wr_en, 0);
        tick(1);
        chk("wr_en_latency", wr_en, 1);
        chk("wr_addr", wr_addr, 16'h0042);
        chk("wr_data", wr_data, 16'hBEEF);
        chk("wr_be", wr_be, 2'b11);
        tick(1);
        chk("wr_en_one_cycle", wr_en, 0);
        finish_cs();
        chk("wr_count", wr_cnt - w0, 1);
        chk("wr_no_rd", rd_cnt - r0, 0);
        chk("wr_hold_data", wr_data, 16'hBEEF);

        // Read with fast fabric response
        snap();
        start(16'h0010);
        gpmc_oe_n = 1'b0;
        tick(2);
        chk("rd_en_early", rd_en, 0);
        tick(1);
        chk("rd_en_latency", rd_en, 1);
        chk("rd_addr", rd_addr, 16'h0010);
        chk("rd_wait_1", gpmc_wait, 1);
        tick(1);
        chk("rd_en_one_cycle", rd_en, 0);
        chk("rd_wait_2", gpmc_wait, 1);
        rd_data = 16'h1234; rd_valid = 1'b1;
        tick(1);
        rd_valid = 1'b0; rd_data = 16'h0000;
        chk("rd_wait_clear", gpmc_wait, 0);
        chk("rd_data_i", gpmc_data_i, 16'h1234);
        tick(3);
        chk("rd_data_hold", gpmc_data_i, 16'h1234);
        finish_cs();
        chk("rd_data_retained", gpmc_data_i, 16'h1234);
        chk("rd_count", rd_cnt - r0, 1);
        chk("rd_no_wr", wr_cnt - w0, 0);

        // Read timeout
        snap();
        start(16'h0020);
        gpmc_oe_n = 1'b0;
        tick(3);
        chk("to_rd_en", rd_en, 1);
        tick(63);
        chk("to_wait_before", gpmc_wait, 1);
        chk("to_no_pulse_yet", to_cnt - t0, 0);
        tick(1);
        chk("to_wait_drop", gpmc_wait, 0);
        chk("to_data_ones", gpmc_data_i, 16'hFFFF);
        chk("to_pulse", rd_timeout, 1);
        tick(1);
        chk("to_pulse_end", rd_timeout, 0);
        finish_cs();
        chk("to_count", to_cnt - t0, 1);

        // Abort during READ_WAIT, late rd_valid ignored
        snap();
        start(16'h0030);
        gpmc_oe_n = 1'b0;
        tick(3);
        chk("ab_wait_set", gpmc_wait, 1);
        gpmc_cs_n = 1'b1;
        tick(3);
        chk("ab_wait_clear", gpmc_wait, 0);
        rd_data = 16'h5555; rd_valid = 1'b1;
        tick(1);
        rd_valid = 1'b0; rd_data = 16'h0000;
        tick(1);
        chk("ab_data_unchanged", gpmc_data_i, 16'hFFFF);
        chk("ab_wait_still_0", gpmc_wait, 0);
        chk("ab_no_timeout", to_cnt - t0, 0);
        gpmc_oe_n = 1'b1;
        tick(6);
        snap();
        do_write(16'h0044, 16'h1357, 2'b00);
        chk("ab_next_wr_count", wr_cnt - w0, 1);
        chk("ab_next_wr_addr", wr_addr, 16'h0044);
        chk("ab_next_wr_data", wr_data, 16'h1357);

        // Byte write
        snap();
        do_write(16'h0050, 16'hA5A5, 2'b10);
        chk("bw_count", wr_cnt - w0, 1);
        chk("bw_be", wr_be, 2'b01);
        chk("bw_data", wr_data, 16'hA5A5);

        // Protocol error: oe_n and we_n low together
        snap();
        start(16'h0060);
        gpmc_oe_n = 1'b0;
        gpmc_we_n = 1'b0;
        tick(10);
        chk("pe_wait", gpmc_wait, 0);
        finish_cs();
        chk("pe_no_wr", wr_cnt - w0, 0);
        chk("pe_no_rd", rd_cnt - r0, 0);

        // Reset between we_n fall and rise
        snap();
        start(16'h0070);
        gpmc_data_o = 16'h9999;
        gpmc_be_n   = 2'b00;
        gpmc_we_n   = 1'b0;
        tick(4);
        rst = 1'b1;
        #1;
        chk("rst_async_wr_bus", {wr_addr, wr_data, wr_be}, 0);
        chk("rst_async_data_i", gpmc_data_i, 0);
        gpmc_we_n = 1'b1;
        gpmc_cs_n = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(6);
        chk("rst_no_wr", wr_cnt - w0, 0);
        chk("rst_outputs", {wr_en, rd_en, rd_timeout, gpmc_wait}, 0);
        snap();
        do_write(16'h0080, 16'h2468, 2'b00);
        chk("rst_next_wr_count", wr_cnt - w0, 1);
        chk("rst_next_wr_addr", wr_addr, 16'h0080);
        chk("rst_next_wr_data", wr_data, 16'h2468);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpmc_slave_bridge.md
Name: gpmc_slave_bridge

Overview:
- Device-side endpoint of the GPMC bus: bridges asynchronous, non-multiplexed GPMC single accesses from the host into single-cycle register read/write strobes in the fabric clock domain.
- Synchronises the GPMC strobes, captures address and write data, issues local requests, and stalls the host via the wait pin until read data returns.
- Feeds the fabric register file and memory decoders.

Parameters:
- ADDR_WIDTH, 16, GPMC address width and local address width.
- DATA_WIDTH, 16, GPMC data width and local data width.
- SYNC_STAGES, 2, flop stages on each GPMC strobe input; minimum 2.
- RD_TIMEOUT, 64, fabric cycles to wait for rd_valid before aborting a read.

Ports:
- clk in 1: fabric clock. Single clock; all logic in this domain.
- rst in 1: asynchronous, active-high reset.
- gpmc_cs_n in 1: chip select for this device, active low.
- gpmc_adv_n in 1: address valid, active low.
- gpmc_oe_n in 1: output enable (read strobe), active low.
- gpmc_we_n in 1: write enable, active low.
- gpmc_be_n in 2: byte enables, active low.
- gpmc_addr in ADDR_WIDTH: address bus.
- gpmc_data_o in DATA_WIDTH: write data driven by the host.
- gpmc_data_i out DATA_WIDTH: read data returned to the host.
- gpmc_wait out 1: stall to host; 1 = wait.
- wr_en out 1: one-cycle write strobe.
- wr_addr out ADDR_WIDTH: write address.
- wr_data out DATA_WIDTH: write data.
- wr_be out 2: write byte enables, active high.
- rd_en out 1: one-cycle read request.
- rd_addr out ADDR_WIDTH: read address.
- rd_data in DATA_WIDTH: read data from fabric.
- rd_valid in 1: rd_data valid this cycle.
- rd_timeout out 1: one-cycle pulse when a read times out.

Behaviour:
- Reset values:
  - all outputs 0, except gpmc_wait = 0;
  - synchroniser flops = 1 (bus idle);
  - FSM in IDLE.
- Synchronisation:
  - cs_n, adv_n, oe_n and we_n each pass through SYNC_STAGES flops.
  - Edges are detected on the last stage against one extra registered copy.
  - gpmc_addr, gpmc_data_o and gpmc_be_n are sampled raw, only on qualified synchronised edges. Host timing must hold them stable for ≥ SYNC_STAGES+2 clk after the relevant strobe edge.
- FSM states: IDLE, ADDR, WRITE, READ_WAIT, READ_HOLD, DONE.
  - IDLE → ADDR: synced cs_n low.
  - ADDR: on synced adv_n rising edge, latch gpmc_addr into the internal address register.
    - Synced we_n falling → WRITE.
    - Synced oe_n falling → assert rd_en for 1 cycle with rd_addr = latched address; set gpmc_wait = 1; go to READ_WAIT.
    - oe_n and we_n both low in the same cycle → protocol error; no request issued; go to DONE.
  - WRITE: on synced we_n rising edge, latch gpmc_data_o and ~gpmc_be_n.
    - Next cycle: wr_en = 1 for exactly one cycle, with wr_addr/wr_data/wr_be valid that cycle and held until the next write.
    - Then go to DONE.
  - READ_WAIT:
    - On rd_valid: register rd_data into gpmc_data_i, clear gpmc_wait the same edge, go to READ_HOLD.
    - Timeout counter counts from rd_en. At RD_TIMEOUT cycles without rd_valid: gpmc_data_i = all ones, rd_timeout pulses 1 cycle, gpmc_wait = 0, go to READ_HOLD.
  - READ_HOLD: gpmc_data_i held until synced oe_n or cs_n rises, then go to DONE.
  - DONE: wait for synced cs_n high, then go to IDLE. gpmc_data_i is retained and not cleared.
- Latency:
  - Raw oe_n fall → rd_en: SYNC_STAGES+1 clk.
  - Raw we_n rise → wr_en: SYNC_STAGES+2 clk.
  - rd_valid → gpmc_data_i / wait clear: 1 clk.
- Abort: synced cs_n rising in any non-IDLE state forces IDLE next cycle.
  - gpmc_wait cleared; no wr_en issued if the we_n rise was not yet seen.
  - An rd_valid arriving in IDLE, ADDR, WRITE or DONE is ignored.
- rd_valid asserted in the same cycle as rd_en is accepted.
- rd_valid asserted in the same cycle as the timeout: rd_valid wins, no rd_timeout pulse.
- Only single accesses are supported: one request per cs_n assertion. A second oe/we strobe before cs_n rises is ignored.
- Asynchronous reset mid-transaction returns all outputs to reset values immediately; no strobe is emitted.

Test Plan:
- Write: cs_n low, addr 0x0042, adv pulse, we_n low then high with data 0xBEEF, be_n 2'b00 → exactly one wr_en with wr_addr 0x0042, wr_data 0xBEEF, wr_be 2'b11; rd_en never asserted.
- Read, fast fabric: addr 0x0010, oe_n low, rd_valid with 0x1234 two cycles after rd_en → gpmc_wait high for 2 cycles then low; gpmc_data_i = 0x1234 until oe_n rises; one rd_en.
- Read timeout: rd_valid never asserted → gpmc_wait drops exactly RD_TIMEOUT cycles after rd_en; gpmc_data_i = 0xFFFF; rd_timeout pulses once.
- Abort: cs_n deasserted while in READ_WAIT, then rd_valid → gpmc_wait 0 next cycle; gpmc_data_i unchanged; FSM in IDLE; next write completes normally.
- Byte write and protocol error: be_n 2'b10 write → wr_be 2'b01. Then oe_n and we_n low together → no wr_en or rd_en.
- Reset mid-write: assert rst between the we_n fall and rise → no wr_en; all outputs 0; next transaction works.
